// File: rtl/uart_cfg_top.sv
// uart_cfg_top: runtime-configurable UART core.
//   Baud tick generator (programmable divisor), 2-FF rx synchroniser,
//   RX/TX serial engines with optional even/odd parity and 1/2 stop bits,
//   RX/TX FIFOs (depth 2^FIFO_EXP, first-word-fall-through on RX) and
//   sticky framing/parity/overrun error flags.
// Optional feature macro: LOOPBACK_EN (adds the loopback input; when high
//   the receiver listens to the internal TX line and the tx pin idles at 1).
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   baud_div            clocks per baud tick (values below 2 act as 2)
//   parity_en/odd       parity enable / odd select, two_stop: TX stop length
//   rx / tx             serial in (async) / serial out
//   write_uart/data     push into TX FIFO; tx_full, tx_level status
//   read_uart           pop RX FIFO; read_data head, rx_empty/full/level
//   frame_err, parity_err, overrun_err   sticky flags; err_clear clears

// Synchronous FIFO with occupancy count; head shown combinationally.
module uart_cfg_fifo #(
    parameter int W = 8,
    parameter int E = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [E:0]   level
);
    localparam int DEPTH = 1 << E;
    localparam logic [E:0] FULL_CNT = (E+1)'(DEPTH);

    logic [W-1:0] mem_r [DEPTH];
    logic [E-1:0] wptr_r;
    logic [E-1:0] rptr_r;
    logic [E:0]   count_r;
    logic         do_push_s;
    logic         do_pop_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == '0);
    assign level     = count_r;
    assign do_pop_s  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees a slot.
    assign do_push_s = push && (!full || do_pop_s);
    assign rdata     = empty ? '0 : mem_r[rptr_r];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (do_push_s) wptr_r <= wptr_r + E'(1);
            if (do_pop_s)  rptr_r <= rptr_r + E'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (E+1)'(1);
                2'b01:   count_r <= count_r - (E+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

module uart_cfg_top #(
    parameter int DBITS      = 8,
    parameter int FIFO_EXP   = 4,
    parameter int DIV_BITS   = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                CLK,
    input  logic                RST,
`ifdef LOOPBACK_EN
    input  logic                loopback,
`endif
    input  logic [DIV_BITS-1:0] baud_div,
    input  logic                parity_en,
    input  logic                parity_odd,
    input  logic                two_stop,
    input  logic                rx,
    output logic                tx,
    input  logic                write_uart,
    input  logic [DBITS-1:0]    write_data,
    output logic                tx_full,
    output logic [FIFO_EXP:0]   tx_level,
    input  logic                read_uart,
    output logic [DBITS-1:0]    read_data,
    output logic                rx_empty,
    output logic                rx_full,
    output logic [FIFO_EXP:0]   rx_level,
    output logic                frame_err,
    output logic                parity_err,
    output logic                overrun_err,
    input  logic                err_clear
);
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    localparam logic [4:0] OS_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] OS_MID   = 5'(OVERSAMPLE / 2 - 1);
    localparam logic [4:0] TWO_LAST = 5'(2 * OVERSAMPLE - 1);
    localparam logic [3:0] D_LAST   = 4'(DBITS - 1);
    localparam logic [DIV_BITS-1:0] DIV_MIN = DIV_BITS'(2);

    function automatic logic [DIV_BITS-1:0] clamp_div(input logic [DIV_BITS-1:0] d);
        if (d < DIV_MIN) clamp_div = DIV_MIN;
        else             clamp_div = d;
    endfunction

    function automatic logic calc_parity(input logic [DBITS-1:0] d, input logic odd);
        calc_parity = (^d) ^ odd;
    endfunction

    // ---------------- baud tick ----------------
    logic [DIV_BITS-1:0] cnt_r;
    logic [DIV_BITS-1:0] div_r;
    logic                tick_s;

    assign tick_s = (cnt_r == div_r - DIV_BITS'(1));

    // Baud counter; the divisor is only re-sampled at a wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r <= '0;
            div_r <= clamp_div(baud_div);
        end else if (tick_s) begin
            cnt_r <= '0;
            div_r <= clamp_div(baud_div);
        end else begin
            cnt_r <= cnt_r + DIV_BITS'(1);
        end
    end

    // ---------------- FIFOs ----------------
    logic             tx_empty_s;
    logic             tx_pop_s;
    logic [DBITS-1:0] tx_head_s;
    logic             rx_push_r;
    logic [DBITS-1:0] rx_sh_r;

    uart_cfg_fifo #(.W(DBITS), .E(FIFO_EXP)) u_tx_fifo (
        .clk(CLK), .rst(RST), .push(write_uart), .pop(tx_pop_s), .wdata(write_data),
        .rdata(tx_head_s), .full(tx_full), .empty(tx_empty_s), .level(tx_level)
    );

    uart_cfg_fifo #(.W(DBITS), .E(FIFO_EXP)) u_rx_fifo (
        .clk(CLK), .rst(RST), .push(rx_push_r), .pop(read_uart), .wdata(rx_sh_r),
        .rdata(read_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    // ---------------- TX engine ----------------
    state_t           tx_state_r;
    logic [4:0]       tx_s_r;
    logic [3:0]       tx_n_r;
    logic [DBITS-1:0] tx_sh_r;
    logic             tx_par_r;
    logic             tx_pen_r;
    logic             tx_two_r;
    logic             tx_r;
    logic [4:0]       tx_stop_last_s;
    logic             tx_start_s;

    // Frame start: on a tick, from idle or straight out of the final stop
    // tick so consecutive frames leave no idle gap.
    always_comb begin
        tx_stop_last_s = OS_LAST;
        tx_start_s     = 1'b0;
        if (tx_two_r) tx_stop_last_s = TWO_LAST;
        else          tx_stop_last_s = OS_LAST;
        if (tick_s && !tx_empty_s &&
            ((tx_state_r == ST_IDLE) || (tx_state_r == ST_STOP && tx_s_r == tx_stop_last_s)))
            tx_start_s = 1'b1;
        else
            tx_start_s = 1'b0;
    end

    assign tx_pop_s = tx_start_s;

    // TX FSM; tx_r is the registered line level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_state_r <= ST_IDLE;
            tx_s_r     <= '0;
            tx_n_r     <= '0;
            tx_sh_r    <= '0;
            tx_par_r   <= 1'b0;
            tx_pen_r   <= 1'b0;
            tx_two_r   <= 1'b0;
            tx_r       <= 1'b1;
        end else if (tx_start_s) begin
            tx_state_r <= ST_START;
            tx_s_r     <= '0;
            tx_sh_r    <= tx_head_s;
            tx_par_r   <= calc_parity(tx_head_s, parity_odd);
            tx_pen_r   <= parity_en;
            tx_two_r   <= two_stop;
            tx_r       <= 1'b0;
        end else if (tick_s) begin
            case (tx_state_r)
                ST_START: begin
                    if (tx_s_r == OS_LAST) begin
                        tx_s_r     <= '0;
                        tx_n_r     <= '0;
                        tx_r       <= tx_sh_r[0];
                        tx_state_r <= ST_DATA;
                    end else begin
                        tx_s_r <= tx_s_r + 5'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_s_r == OS_LAST) begin
                        tx_s_r <= '0;
                        if (tx_n_r == D_LAST) begin
                            if (tx_pen_r) begin
                                tx_state_r <= ST_PARITY;
                                tx_r       <= tx_par_r;
                            end else begin
                                tx_state_r <= ST_STOP;
                                tx_r       <= 1'b1;
                            end
                        end else begin
                            tx_n_r  <= tx_n_r + 4'd1;
                            tx_sh_r <= tx_sh_r >> 1;
                            tx_r    <= tx_sh_r[1];
                        end
                    end else begin
                        tx_s_r <= tx_s_r + 5'd1;
                    end
                end
                ST_PARITY: begin
                    if (tx_s_r == OS_LAST) begin
                        tx_s_r     <= '0;
                        tx_state_r <= ST_STOP;
                        tx_r       <= 1'b1;
                    end else begin
                        tx_s_r <= tx_s_r + 5'd1;
                    end
                end
                ST_STOP: begin
                    if (tx_s_r == tx_stop_last_s) begin
                        tx_state_r <= ST_IDLE;
                        tx_s_r     <= '0;
                    end else begin
                        tx_s_r <= tx_s_r + 5'd1;
                    end
                end
                default: begin
                    tx_state_r <= ST_IDLE;
                    tx_r       <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- rx source and synchroniser ----------------
    logic rx_src_s;
    logic sync1_r;
    logic sync2_r;

`ifdef LOOPBACK_EN
    assign rx_src_s = loopback ? tx_r : rx;
    assign tx       = loopback ? 1'b1 : tx_r;
`else
    assign rx_src_s = rx;
    assign tx       = tx_r;
`endif

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx_src_s;
            sync2_r <= sync1_r;
        end
    end

    // ---------------- RX engine ----------------
    state_t     rx_state_r;
    logic [4:0] rx_s_r;
    logic [3:0] rx_n_r;
    logic       rx_pen_r;
    logic       rx_podd_r;
    logic       rx_perr_r;
    logic       frame_err_r;
    logic       parity_err_r;
    logic       overrun_err_r;

    assign frame_err   = frame_err_r;
    assign parity_err  = parity_err_r;
    assign overrun_err = overrun_err_r;

    // RX FSM plus sticky flags; an event later in this block overrides err_clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_state_r    <= ST_IDLE;
            rx_s_r        <= '0;
            rx_n_r        <= '0;
            rx_sh_r       <= '0;
            rx_pen_r      <= 1'b0;
            rx_podd_r     <= 1'b0;
            rx_perr_r     <= 1'b0;
            rx_push_r     <= 1'b0;
            frame_err_r   <= 1'b0;
            parity_err_r  <= 1'b0;
            overrun_err_r <= 1'b0;
        end else begin
            rx_push_r <= 1'b0;
            if (err_clear) begin
                frame_err_r   <= 1'b0;
                parity_err_r  <= 1'b0;
                overrun_err_r <= 1'b0;
            end
            case (rx_state_r)
                ST_IDLE: begin
                    if (!sync2_r) begin
                        rx_state_r <= ST_START;
                        rx_s_r     <= '0;
                        rx_pen_r   <= parity_en;
                        rx_podd_r  <= parity_odd;
                        rx_perr_r  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        if (rx_s_r == OS_MID) begin
                            // Line back high at mid start bit: treat as a glitch.
                            if (sync2_r) begin
                                rx_state_r <= ST_IDLE;
                            end else begin
                                rx_state_r <= ST_DATA;
                                rx_s_r     <= '0;
                                rx_n_r     <= '0;
                            end
                        end else begin
                            rx_s_r <= rx_s_r + 5'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        if (rx_s_r == OS_LAST) begin
                            rx_s_r  <= '0;
                            rx_sh_r <= {sync2_r, rx_sh_r[DBITS-1:1]};
                            if (rx_n_r == D_LAST) begin
                                if (rx_pen_r) rx_state_r <= ST_PARITY;
                                else          rx_state_r <= ST_STOP;
                            end else begin
                                rx_n_r <= rx_n_r + 4'd1;
                            end
                        end else begin
                            rx_s_r <= rx_s_r + 5'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick_s) begin
                        if (rx_s_r == OS_LAST) begin
                            rx_s_r     <= '0;
                            rx_perr_r  <= sync2_r ^ calc_parity(rx_sh_r, rx_podd_r);
                            rx_state_r <= ST_STOP;
                        end else begin
                            rx_s_r <= rx_s_r + 5'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        if (rx_s_r == OS_LAST) begin
                            rx_s_r     <= '0;
                            rx_state_r <= ST_IDLE;
                            if (!sync2_r)      frame_err_r   <= 1'b1;
                            else if (rx_perr_r) parity_err_r <= 1'b1;
                            else if (rx_full)  overrun_err_r <= 1'b1;
                            else               rx_push_r     <= 1'b1;
                        end else begin
                            rx_s_r <= rx_s_r + 5'd1;
                        end
                    end
                end
                default: rx_state_r <= ST_IDLE;
            endcase
        end
    end
endmodule
